// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus a single-outstanding instruction fetch.
// The unit fetches one instruction, holds it for execution, and at commit picks
// the next PC, in priority order: jump, then branch, then sequential.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   Branch_in, Jump_in,
//   JumpReg_in                  - control-transfer flags for the current instruction
//   Target_in                   - register target for JR/JALR
//   BranchOffset_in             - signed word offset for branches
//   JumpIndex_in                - 26-bit jump index for J/JAL
//   Commit_in, Stall_in         - commit pulse; a stall masks the commit
//   ImemReq_out, ImemAddr_out   - fetch request and its address
//   ImemReady_in, ImemData_in   - memory accept and the returned instruction word
//   Instr_out, InstrValid_out   - registered instruction and its valid flag
//   PC_out, PCPlus4_out         - current PC and PC+4 (the link value)
//   Fault_out                   - sticky misaligned-target flag
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Branch_in,
    input  logic        Jump_in,
    input  logic        JumpReg_in,
    input  logic [31:0] Target_in,
    input  logic [15:0] BranchOffset_in,
    input  logic [25:0] JumpIndex_in,
    input  logic        Commit_in,
    input  logic        Stall_in,
    output logic        ImemReq_out,
    output logic [31:0] ImemAddr_out,
    input  logic        ImemReady_in,
    input  logic [31:0] ImemData_in,
    output logic [31:0] Instr_out,
    output logic        InstrValid_out,
    output logic [31:0] PC_out,
    output logic [31:0] PCPlus4_out,
    output logic        Fault_out
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        req;
    logic        fault;

    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        commit;

    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{BranchOffset_in[15]}}, BranchOffset_in, 2'b00};
    assign commit     = Commit_in & ~Stall_in;

    // Only a register target can be misaligned: branch and J/JAL targets
    // are built from the (aligned) PC and a word-scaled field.
    assign misaligned = Jump_in & JumpReg_in & (Target_in[1:0] != 2'b00);

    always_comb begin
        next_pc = pc_plus4;
        if (Jump_in) begin
            if (JumpReg_in) begin
                next_pc = Target_in;
            end else begin
                next_pc = {pc_plus4[31:28], JumpIndex_in, 2'b00};
            end
        end else if (Branch_in) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            instr <= 32'h0;
            valid <= 1'b0;
            req   <= 1'b1;
            fault <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (ImemReady_in) begin
                        instr <= ImemData_in;
                        valid <= 1'b1;
                        req   <= 1'b0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (commit) begin
                        valid <= 1'b0;
                        if (misaligned) begin
                            // PC is left pointing at the faulting instruction.
                            fault <= 1'b1;
                            req   <= 1'b0;
                            state <= FAULT;
                        end else begin
                            pc    <= next_pc;
                            req   <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    req   <= 1'b0;
                    valid <= 1'b0;
                end
                default: begin
                    req   <= 1'b0;
                    valid <= 1'b0;
                    fault <= 1'b1;
                    state <= FAULT;
                end
            endcase
        end
    end

    assign ImemReq_out    = req;
    assign ImemAddr_out   = pc;
    assign Instr_out      = instr;
    assign InstrValid_out = valid;
    assign PC_out         = pc;
    assign PCPlus4_out    = pc_plus4;
    assign Fault_out      = fault;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: self-checking bench for pc_fetch_unit.
// Vector table for next-PC rules, directed corner sequences, random program model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Branch_in, Jump_in, JumpReg_in;
    logic [31:0] Target_in;
    logic [15:0] BranchOffset_in;
    logic [25:0] JumpIndex_in;
    logic        Commit_in, Stall_in;
    logic        ImemReq_out;
    logic [31:0] ImemAddr_out;
    logic        ImemReady_in;
    logic [31:0] ImemData_in;
    logic [31:0] Instr_out;
    logic        InstrValid_out;
    logic [31:0] PC_out, PCPlus4_out;
    logic        Fault_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .Branch_in(Branch_in), .Jump_in(Jump_in), .JumpReg_in(JumpReg_in),
        .Target_in(Target_in), .BranchOffset_in(BranchOffset_in),
        .JumpIndex_in(JumpIndex_in), .Commit_in(Commit_in), .Stall_in(Stall_in),
        .ImemReq_out(ImemReq_out), .ImemAddr_out(ImemAddr_out),
        .ImemReady_in(ImemReady_in), .ImemData_in(ImemData_in),
        .Instr_out(Instr_out), .InstrValid_out(InstrValid_out),
        .PC_out(PC_out), .PCPlus4_out(PCPlus4_out), .Fault_out(Fault_out)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        br;
        logic        j;
        logic        jr;
        logic [31:0] tgt;
        logic [15:0] off;
        logic [25:0] idx;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        Branch_in = 0; Jump_in = 0; JumpReg_in = 0;
        Target_in = 0; BranchOffset_in = 0; JumpIndex_in = 0;
        Commit_in = 0; Stall_in = 0; ImemReady_in = 0; ImemData_in = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // Fetch with a number of wait cycles; address must hold throughout.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                         input int waits);
        for (int i = 0; i < waits; i++) begin
            ImemReady_in = 0;
            ImemData_in  = $urandom;
            chk("fetch_wait_req", 32'(ImemReq_out), 32'd1);
            chk("fetch_wait_addr", ImemAddr_out, exp_addr);
            tick();
        end
        ImemReady_in = 1;
        ImemData_in  = data;
        chk("fetch_req", 32'(ImemReq_out), 32'd1);
        chk("fetch_addr", ImemAddr_out, exp_addr);
        tick();
        ImemReady_in = 0;
        chk("fetch_instr", Instr_out, data);
        chk("fetch_valid", 32'(InstrValid_out), 32'd1);
        chk("fetch_req_low", 32'(ImemReq_out), 32'd0);
    endtask

    task automatic commit(input logic br, input logic j, input logic jr,
                          input logic [31:0] tgt, input logic [15:0] off,
                          input logic [25:0] idx);
        Branch_in = br; Jump_in = j; JumpReg_in = jr;
        Target_in = tgt; BranchOffset_in = off; JumpIndex_in = idx;
        Commit_in = 1; Stall_in = 0;
        tick();
        idle_inputs();
    endtask

    task automatic set_pc(input logic [31:0] p);
        do_reset();
        fetch(RST_PC, $urandom | 32'h1, 0);
        commit(0, 1, 1, p, 16'h0, 26'h0);
        chk("set_pc", ImemAddr_out, p);
    endtask

    // Reference next-PC from the architectural rules.
    function automatic logic [31:0] model_next(
        input logic [31:0] pc, input logic br, input logic j, input logic jr,
        input logic [31:0] tgt, input logic [15:0] off, input logic [25:0] idx);
        logic [31:0] p4;
        int signed   s;
        p4 = pc + 32'd4;
        s  = $signed(off);
        if (j && jr) return tgt;
        if (j) return (p4 & 32'hF000_0000) + ({6'd0, idx} * 32'd4);
        if (br) return p4 + 32'(s * 4);
        return p4;
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] mpc, np, tgt, data;
        logic        br, j, jr, bad;
        logic [15:0] off;
        logic [25:0] idx;
        int          w, st;

        vecs[0] = '{"br_back", 32'h10, 1, 0, 0, 0, 16'hFFFC, 0, 32'h4, 0};
        vecs[1] = '{"j_idx", 32'h1000_0000, 0, 1, 0, 0, 0, 26'h40,
                    32'h1000_0100, 0};
        vecs[2] = '{"jr_misal", 32'h80, 0, 1, 1, 32'h102, 0, 0, 32'h80, 1};
        vecs[3] = '{"seq_wrap", 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'h0, 0};
        vecs[4] = '{"br_and_j", 32'h100, 1, 1, 0, 0, 16'h0010, 26'h3FF_FFFF,
                    32'h0FFF_FFFC, 0};
        vecs[5] = '{"jr_ok", 32'h200, 0, 1, 1, 32'h8000_0000, 0, 0,
                    32'h8000_0000, 0};
        vecs[6] = '{"br_wrap", 32'hFFFF_FFF0, 1, 0, 0, 0, 16'h0004, 0,
                    32'h4, 0};
        vecs[7] = '{"j_wrap", 32'hFFFF_FFFC, 0, 1, 0, 0, 0, 26'h1, 32'h4, 0};
        vecs[8] = '{"jr_misal_br", 32'h40, 1, 1, 1, 32'h41, 16'h8, 0,
                    32'h40, 1};
        vecs[9] = '{"br_fwd_max", 32'h8000, 1, 0, 0, 0, 16'h7FFF, 0,
                    32'h0002_8000, 0};

        reset = 0;
        idle_inputs();

        // Reset state and the four-cycle held fetch.
        do_reset();
        chk("rst_req", 32'(ImemReq_out), 32'd1);
        chk("rst_addr", ImemAddr_out, RST_PC);
        chk("rst_pc4", PCPlus4_out, RST_PC + 32'd4);
        chk("rst_valid", 32'(InstrValid_out), 32'd0);
        chk("rst_instr", Instr_out, 32'd0);
        chk("rst_fault", 32'(Fault_out), 32'd0);
        fetch(32'h0, 32'h2008_0005, 3);

        // Memory ready while executing must not replace the instruction.
        ImemReady_in = 1;
        ImemData_in  = 32'hDEAD_BEEF;
        tick();
        tick();
        idle_inputs();
        chk("exec_ready_instr", Instr_out, 32'h2008_0005);
        chk("exec_ready_valid", 32'(InstrValid_out), 32'd1);
        chk("exec_ready_req", 32'(ImemReq_out), 32'd0);

        // Table of next-PC cases.
        foreach (vecs[k]) begin
            set_pc(vecs[k].pc);
            fetch(vecs[k].pc, $urandom, $urandom_range(0, 2));
            commit(vecs[k].br, vecs[k].j, vecs[k].jr, vecs[k].tgt,
                   vecs[k].off, vecs[k].idx);
            chk({vecs[k].name, "_addr"}, ImemAddr_out, vecs[k].exp_pc);
            chk({vecs[k].name, "_fault"}, 32'(Fault_out),
                32'(vecs[k].exp_fault));
            chk({vecs[k].name, "_req"}, 32'(ImemReq_out),
                32'(!vecs[k].exp_fault));
            chk({vecs[k].name, "_valid"}, 32'(InstrValid_out), 32'd0);
        end

        // Commit held under stall, then exactly one commit.
        set_pc(32'h40);
        fetch(32'h40, 32'h1111_2222, 1);
        Commit_in = 1; Stall_in = 1; Branch_in = 1; BranchOffset_in = 16'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_addr", ImemAddr_out, 32'h40);
            chk("stall_valid", 32'(InstrValid_out), 32'd1);
        end
        Stall_in = 0;
        tick();
        chk("stall_commit_addr", ImemAddr_out, 32'h84);
        tick();
        tick();
        chk("stall_once_addr", ImemAddr_out, 32'h84);
        chk("stall_once_req", 32'(ImemReq_out), 32'd1);
        idle_inputs();

        // Fault is sticky until reset.
        set_pc(32'h100);
        fetch(32'h100, 32'h3333_4444, 0);
        commit(0, 1, 1, 32'h102, 16'h0, 26'h0);
        ImemReady_in = 1; Commit_in = 1; Jump_in = 1; JumpReg_in = 1;
        Target_in = 32'h200;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fault_sticky", 32'(Fault_out), 32'd1);
            chk("fault_req", 32'(ImemReq_out), 32'd0);
            chk("fault_valid", 32'(InstrValid_out), 32'd0);
            chk("fault_addr", ImemAddr_out, 32'h100);
        end
        do_reset();
        chk("fault_clear", 32'(Fault_out), 32'd0);
        chk("fault_clear_req", 32'(ImemReq_out), 32'd1);

        // Reset beats a same-cycle fetch handshake.
        set_pc(32'h300);
        ImemReady_in = 0;
        tick();
        reset = 1; ImemReady_in = 1; ImemData_in = 32'h1234_5678;
        tick();
        reset = 0;
        idle_inputs();
        chk("rst_mid_instr", Instr_out, 32'd0);
        chk("rst_mid_valid", 32'(InstrValid_out), 32'd0);
        chk("rst_mid_addr", ImemAddr_out, RST_PC);
        chk("rst_mid_req", 32'(ImemReq_out), 32'd1);

        // Random program against the reference.
        do_reset();
        mpc = RST_PC;
        for (int k = 0; k < 300; k++) begin
            w    = $urandom_range(0, 3);
            data = $urandom;
            fetch(mpc, data, w);
            st = $urandom_range(0, 2);
            Commit_in = 1; Stall_in = 1;
            for (int i = 0; i < st; i++) begin
                tick();
                chk("rnd_stall_addr", ImemAddr_out, mpc);
            end
            br  = 1'($urandom_range(0, 1));
            j   = ($urandom_range(0, 3) == 0);
            jr  = 1'($urandom_range(0, 1));
            off = 16'($urandom);
            idx = 26'($urandom);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            bad = j && jr && (tgt[1:0] != 2'b00);
            np  = model_next(mpc, br, j, jr, tgt, off, idx);
            commit(br, j, jr, tgt, off, idx);
            chk("rnd_fault", 32'(Fault_out), 32'(bad));
            if (bad) begin
                chk("rnd_fault_addr", ImemAddr_out, mpc);
                chk("rnd_fault_req", 32'(ImemReq_out), 32'd0);
                do_reset();
                mpc = RST_PC;
            end else begin
                chk("rnd_addr", ImemAddr_out, np);
                chk("rnd_pc4", PCPlus4_out, np + 32'd4);
                chk("rnd_valid", 32'(InstrValid_out), 32'd0);
                mpc = np;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
